// File: rtl/regfile_param_if.sv
// regfile_param_if: write, read, dirty and dump signals of the parametrised register file
interface regfile_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  localparam int DEPTH = 2**ADDR_W;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr_1;
  logic [DATA_W-1:0] rd_data_1;
  logic [ADDR_W-1:0] rd_addr_2;
  logic [DATA_W-1:0] rd_data_2;
  logic [DEPTH-1:0]  dirty;
  logic              dump_start;
  logic              dump_ready;
  logic              dump_valid;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              dump_last;
  logic              dump_busy;
  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_1, rd_addr_2, dump_start, dump_ready,
    input  rd_data_1, rd_data_2, dirty, dump_valid, dump_addr, dump_data, dump_last, dump_busy
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_1, rd_addr_2, dump_start, dump_ready,
    output rd_data_1, rd_data_2, dirty, dump_valid, dump_addr, dump_data, dump_last, dump_busy
  );
endinterface

// File: rtl/regfile_param.sv
// regfile_param: 2R1W register file with optional zero register, bypass, dirty flags and dump engine
module regfile_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1,
  parameter logic [(2**ADDR_W)*DATA_W-1:0] RESET_VEC = '0
) (
  input logic clk,
  input logic rst,
  regfile_param_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH-1);
  typedef enum logic {IDLE, RUN} state_t;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  dirty_q;
  logic              we_ok;
  state_t            state, state_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic [DATA_W-1:0] data_q, data_n;
  assign we_ok = bus.wr_en && !(ZERO_REG != 0 && bus.wr_addr == '0);
  assign bus.rd_data_1 = (ZERO_REG != 0 && bus.rd_addr_1 == '0) ? '0 :
                         (BYPASS != 0 && bus.wr_en && bus.wr_addr == bus.rd_addr_1) ? bus.wr_data :
                         mem[bus.rd_addr_1];
  assign bus.rd_data_2 = (ZERO_REG != 0 && bus.rd_addr_2 == '0) ? '0 :
                         (BYPASS != 0 && bus.wr_en && bus.wr_addr == bus.rd_addr_2) ? bus.wr_data :
                         mem[bus.rd_addr_2];
  assign bus.dirty      = dirty_q;
  assign bus.dump_valid = state == RUN;
  assign bus.dump_busy  = state == RUN;
  assign bus.dump_addr  = idx;
  assign bus.dump_data  = data_q;
  assign bus.dump_last  = state == RUN && idx == LAST;
  // register array and dirty flags; register 0 stays zero when hardwired
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= (ZERO_REG != 0 && i == 0) ? '0 : RESET_VEC[i*DATA_W +: DATA_W];
      dirty_q <= '0;
    end else if (we_ok) begin
      mem[bus.wr_addr]     <= bus.wr_data;
      dirty_q[bus.wr_addr] <= 1'b1;
    end
  // dump engine state and current beat
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state  <= IDLE;
      idx    <= '0;
      data_q <= '0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      data_q <= data_n;
    end
  // next beat is sampled from the array without bypass, so same-edge writes show up only in later beats
  always_comb begin
    state_n = state;
    idx_n   = idx;
    data_n  = data_q;
    if (state == IDLE && bus.dump_start) begin
      state_n = RUN;
      idx_n   = '0;
      data_n  = mem[0];
    end else if (state == RUN && bus.dump_ready) begin
      state_n = (idx == LAST) ? IDLE : RUN;
      idx_n   = (idx == LAST) ? '0 : idx + 1'b1;
      data_n  = (idx == LAST) ? '0 : mem[idx + 1'b1];
    end
  end
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed checks of reads, bypass, zero register, dirty flags, dump and async reset
module tb_regfile_param;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  regfile_param_if #(.DATA_W(8), .ADDR_W(3)) bus ();
  regfile_param dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask
  initial begin
    int b;
    int cyc;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_addr_1 = '0;
    bus.rd_addr_2 = '0;
    bus.dump_start = 1'b0;
    bus.dump_ready = 1'b0;
    #12;
    @(negedge clk);
    rst = 1'b1;
    for (int a = 0; a < 8; a++) begin
      bus.rd_addr_1 = 3'(a);
      bus.rd_addr_2 = 3'(7 - a);
      #1;
      check("reset_rd1", bus.rd_data_1, 0);
      check("reset_rd2", bus.rd_data_2, 0);
    end
    check("reset_dirty", bus.dirty, 8'h00);
    check("reset_busy", bus.dump_busy, 0);
    check("reset_valid", bus.dump_valid, 0);
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.wr_addr = 3'd3;
    bus.wr_data = 8'hA5;
    bus.rd_addr_1 = 3'd3;
    #1;
    check("bypass_rd1", bus.rd_data_1, 8'hA5);
    @(negedge clk);
    bus.wr_en = 1'b0;
    #1;
    check("after_wr_rd1", bus.rd_data_1, 8'hA5);
    check("after_wr_dirty", bus.dirty, 8'h08);
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.wr_addr = 3'd0;
    bus.wr_data = 8'hFF;
    bus.rd_addr_2 = 3'd0;
    #1;
    check("zero_during", bus.rd_data_2, 0);
    @(negedge clk);
    bus.wr_en = 1'b0;
    #1;
    check("zero_after", bus.rd_data_2, 0);
    check("zero_dirty", bus.dirty, 8'h08);
    for (int i = 1; i < 8; i++) wr(3'(i), 8'(i));
    bus.rd_addr_1 = 3'd3;
    bus.rd_addr_2 = 3'd7;
    #1;
    check("fill_rd3", bus.rd_data_1, 3);
    check("fill_rd7", bus.rd_data_2, 7);
    check("fill_dirty", bus.dirty, 8'hFE);
    @(negedge clk);
    bus.dump_start = 1'b1;
    bus.dump_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.dump_start = 1'b0;
      check("dump_valid", bus.dump_valid, 1);
      check("dump_addr", bus.dump_addr, i);
      check("dump_data", bus.dump_data, i);
      check("dump_last", bus.dump_last, i == 7);
      check("dump_busy", bus.dump_busy, 1);
    end
    @(negedge clk);
    check("dump_end_busy", bus.dump_busy, 0);
    check("dump_end_valid", bus.dump_valid, 0);
    check("dump_end_last", bus.dump_last, 0);
    bus.dump_ready = 1'b0;
    bus.dump_start = 1'b1;
    b = 0;
    cyc = 0;
    while (b < 8 && cyc < 40) begin
      @(negedge clk);
      check("tog_valid", bus.dump_valid, 1);
      check("tog_addr", bus.dump_addr, b);
      check("tog_data", bus.dump_data, b);
      check("tog_last", bus.dump_last, b == 7);
      bus.dump_ready = (cyc % 2) == 0;
      bus.dump_start = cyc == 5;
      if (bus.dump_ready) b++;
      cyc++;
    end
    check("tog_beats", b, 8);
    @(negedge clk);
    bus.dump_ready = 1'b0;
    bus.dump_start = 1'b0;
    check("tog_end_busy", bus.dump_busy, 0);
    repeat (2) @(negedge clk);
    check("tog_no_restart", bus.dump_busy, 0);
    bus.dump_start = 1'b1;
    bus.dump_ready = 1'b1;
    repeat (5) @(negedge clk);
    bus.dump_start = 1'b0;
    check("pre_rst_addr", bus.dump_addr, 4);
    bus.dump_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", bus.dump_valid, 0);
    check("arst_busy", bus.dump_busy, 0);
    check("arst_last", bus.dump_last, 0);
    check("arst_addr", bus.dump_addr, 0);
    check("arst_data", bus.dump_data, 0);
    check("arst_dirty", bus.dirty, 8'h00);
    for (int a = 0; a < 8; a++) begin
      bus.rd_addr_1 = 3'(a);
      #1;
      check("arst_rd", bus.rd_data_1, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.dump_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_valid", bus.dump_valid, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
